// File: rtl/port_deserializer_pkg.sv
// Shared types and sizing for the eight-slot port deserializer.
package port_deserializer_pkg;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_e;

    localparam int SLOT_NUM = 8;
    localparam int IDX_W    = 3;
    localparam int CNT_W    = 4;

endpackage

// File: rtl/port_deserializer_ctrl.sv
// Frame sequencing for the deserializer: state, slot index and word count.
//   state   | meaning
//   COLLECT | accepting words into slots, in_ready=1
//   HOLD    | frame presented downstream, out_valid=1
module port_deserializer_ctrl
    import port_deserializer_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             in_last,
    input  logic             out_ready,
    output logic             in_ready,
    output logic             out_valid,
    output logic             in_fire,
    output logic             out_fire,
    output logic             frame_close,
    output logic [IDX_W-1:0] idx,
    output logic [CNT_W-1:0] cnt
);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;

    assign in_fire     = in_valid && in_ready_q;
    assign out_fire    = out_valid_q && out_ready;
    assign frame_close = in_fire && ((idx_q == IDX_W'(SLOT_NUM - 1)) || in_last);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        case (state_q)
            COLLECT: begin
                if (frame_close) begin
                    state_d     = HOLD;
                    cnt_d       = CNT_W'(idx_q) + CNT_W'(1);
                    idx_d       = '0;
                    in_ready_d  = 1'b0;
                    out_valid_d = 1'b1;
                end else if (in_fire) begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            HOLD: begin
                if (out_fire) begin
                    state_d     = COLLECT;
                    cnt_d       = '0;
                    in_ready_d  = 1'b1;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = COLLECT;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= COLLECT;
            idx_q       <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign idx       = idx_q;
    assign cnt       = cnt_q;

endmodule

// File: rtl/port_deserializer.sv
// Collects up to eight words into slots a..h and presents them as one frame
// with the bitwise-AND word and reduction-AND flag.
module port_deserializer
    import port_deserializer_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] e,
    output logic [WIDTH-1:0] f,
    output logic [WIDTH-1:0] g,
    output logic [WIDTH-1:0] h,
    output logic [WIDTH-1:0] and_w,
    output logic [WIDTH-1:0] q,
    output logic [3:0]       cnt
);

    logic             in_fire;
    logic             out_fire;
    logic             frame_close;
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] cnt_int;

    logic [WIDTH-1:0] slot_q [SLOT_NUM];
    logic [WIDTH-1:0] slot_d [SLOT_NUM];
    logic [WIDTH-1:0] and_w_q, and_w_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] and_next;

    port_deserializer_ctrl u_ctrl (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_last     (in_last),
        .out_ready   (out_ready),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .in_fire     (in_fire),
        .out_fire    (out_fire),
        .frame_close (frame_close),
        .idx         (idx),
        .cnt         (cnt_int)
    );

    assign and_next = and_w_q & in_data;

    // Slots and AND word idle at all-ones so padding never disturbs the reduction.
    always_comb begin
        slot_d  = slot_q;
        and_w_d = and_w_q;
        q_d     = q_q;
        if (out_fire) begin
            for (int i = 0; i < SLOT_NUM; i++) begin
                slot_d[i] = '1;
            end
            and_w_d = '1;
            q_d     = '0;
        end else if (in_fire) begin
            slot_d[idx] = in_data;
            and_w_d     = and_next;
            if (frame_close) begin
                q_d    = '0;
                q_d[0] = &and_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < SLOT_NUM; i++) begin
                slot_q[i] <= '1;
            end
            and_w_q <= '1;
            q_q     <= '0;
        end else begin
            slot_q  <= slot_d;
            and_w_q <= and_w_d;
            q_q     <= q_d;
        end
    end

    assign a     = slot_q[0];
    assign b     = slot_q[1];
    assign c     = slot_q[2];
    assign d     = slot_q[3];
    assign e     = slot_q[4];
    assign f     = slot_q[5];
    assign g     = slot_q[6];
    assign h     = slot_q[7];
    assign and_w = and_w_q;
    assign q     = q_q;
    assign cnt   = cnt_int;

endmodule

// File: tb/tb_port_deserializer.sv
// Self-checking bench for port_deserializer at WIDTH=7 with a frame scoreboard.
module tb_port_deserializer;
    import port_deserializer_pkg::*;

    localparam int W = 7;
    localparam logic [W-1:0] ONES = '1;

    typedef struct packed {
        logic [SLOT_NUM*W-1:0] slots;
        logic [W-1:0]          and_w;
        logic [W-1:0]          q;
        logic [3:0]            cnt;
    } frame_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         in_last;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] a, b, c, d, e, f, g, h;
    logic [W-1:0] and_w;
    logic [W-1:0] q;
    logic [3:0]   cnt;
    logic [W-1:0] obs [SLOT_NUM];

    int n_cmp = 0;
    int n_err = 0;
    int n_out = 0;

    frame_t                sb [$];
    logic [SLOT_NUM*W-1:0] m_slots;
    logic [W-1:0]          m_and;
    int                    m_idx;

    always #5 clk = ~clk;

    port_deserializer #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .a         (a),
        .b         (b),
        .c         (c),
        .d         (d),
        .e         (e),
        .f         (f),
        .g         (g),
        .h         (h),
        .and_w     (and_w),
        .q         (q),
        .cnt       (cnt)
    );

    assign obs[0] = a;
    assign obs[1] = b;
    assign obs[2] = c;
    assign obs[3] = d;
    assign obs[4] = e;
    assign obs[5] = f;
    assign obs[6] = g;
    assign obs[7] = h;

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_cmp++;
        assert (observed === expected) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic model_clear();
        m_slots = '1;
        m_and   = '1;
        m_idx   = 0;
    endtask

    // Reference model and scoreboard, sampled mid-cycle on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            model_clear();
            sb.delete();
        end else if (sb.size() != 0) begin
            chk("out_valid_hold", out_valid, 1);
            chk("in_ready_hold", in_ready, 0);
            for (int k = 0; k < SLOT_NUM; k++) begin
                chk($sformatf("slot%0d", k), obs[k], sb[0].slots[k*W +: W]);
            end
            chk("and_w", and_w, sb[0].and_w);
            chk("q", q, sb[0].q);
            chk("cnt", cnt, sb[0].cnt);
            if (out_ready) begin
                void'(sb.pop_front());
                n_out++;
            end
        end else begin
            chk("out_valid_collect", out_valid, 0);
            chk("in_ready_collect", in_ready, 1);
            if (in_valid) begin
                m_slots[m_idx*W +: W] = in_data;
                m_and = m_and & in_data;
                if (m_idx == SLOT_NUM - 1 || in_last) begin
                    sb.push_back('{slots: m_slots, and_w: m_and,
                                   q: {{(W-1){1'b0}}, &m_and}, cnt: 4'(m_idx + 1)});
                    model_clear();
                end else begin
                    m_idx++;
                end
            end
        end
    end

    task automatic drive(input logic v, input logic [W-1:0] dat, input logic l, input logic r);
        in_valid  = v;
        in_data   = dat;
        in_last   = l;
        out_ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_view(input string tag);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_in_ready"}, in_ready, 1);
        for (int k = 0; k < SLOT_NUM; k++) begin
            chk($sformatf("%s_slot%0d", tag, k), obs[k], ONES);
        end
        chk({tag, "_and_w"}, and_w, ONES);
        chk({tag, "_q"}, q, 0);
        chk({tag, "_cnt"}, cnt, 0);
    endtask

    initial begin
        int base;
        model_clear();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        check_reset_view("reset");
        rst_n = 1'b1;
        drive(0, 0, 0, 0);

        // Full frame of ones; out_valid must follow the 8th transfer by one cycle.
        for (int i = 0; i < SLOT_NUM; i++) begin
            chk("lat_pre_ov", out_valid, 0);
            drive(1, 7'h7F, 0, 0);
        end
        chk("lat_ov", out_valid, 1);
        chk("lat_q", q, 1);
        drive(0, 0, 0, 1);
        chk("release_in_ready", in_ready, 1);

        // One cleared bit in slot d.
        for (int i = 0; i < SLOT_NUM; i++) begin
            drive(1, (i == 3) ? 7'h3F : 7'h7F, 0, 0);
        end
        chk("d_slot", d, 7'h3F);
        drive(0, 0, 0, 1);

        // Short frame closed by in_last.
        drive(1, 7'h55, 0, 0);
        drive(1, 7'h7F, 0, 0);
        drive(1, 7'h7F, 1, 0);
        chk("short_cnt", cnt, 3);
        chk("short_and", and_w, 7'h55);
        drive(0, 0, 0, 1);

        // Full frame, then backpressure while zeros are offered.
        for (int i = 0; i < SLOT_NUM; i++) begin
            drive(1, W'(i + 1) | 7'h70, 0, 0);
        end
        for (int i = 0; i < 5; i++) begin
            drive(1, 7'h00, 0, 0);
        end
        drive(1, 7'h00, 0, 1);
        chk("bp_in_ready", in_ready, 1);
        for (int i = 0; i < SLOT_NUM; i++) begin
            drive(1, 7'h00, 0, 0);
        end
        chk("zero_a", a, 7'h00);
        drive(0, 0, 0, 1);

        // Reset mid-frame after 4 words.
        for (int i = 0; i < 4; i++) begin
            drive(1, 7'h0A, 0, 0);
        end
        rst_n = 1'b0;
        drive(1, 7'h11, 0, 1);
        rst_n = 1'b1;
        check_reset_view("midrst");
        for (int i = 0; i < SLOT_NUM; i++) begin
            drive(1, W'(i + 1), 0, 0);
        end
        chk("fresh_a", a, 7'h01);
        chk("fresh_h", h, 7'h08);
        drive(0, 0, 0, 1);

        // Random gaps and short frames.
        base = n_out;
        for (int cyc = 0; cyc < 3000 && n_out < base + 10; cyc++) begin
            drive(($urandom_range(0, 3) != 0), W'($urandom), ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 2) != 0));
        end
        chk("rand_frames", (n_out - base >= 10), 1);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 1);
        end
        chk("sb_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/port_deserializer.md
# port_deserializer

Streaming front-end for the eight-port reduction datapath. It accepts WIDTH-bit words one per handshake on a valid/ready input and distributes them into eight parallel slots, a through h. It then presents the whole frame at once, together with its bitwise-AND word and reduction-AND flag, under a valid/ready output handshake. Short frames closed by in_last are padded with all-ones, which is the AND identity, so downstream reduction results are unaffected.

## Interface
- WIDTH, default 8: word width in bits, minimum 1.
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block accepts in_data this cycle.
- in_data  input  WIDTH  input word.
- in_last  input  1  marks the final word of a short frame; qualified by in_valid.
- out_valid  output  1  frame is presented on a..h, and_w, q, cnt.
- out_ready  input  1  downstream accepts the frame.
- a, b, c, d, e, f, g, h  output  WIDTH each  frame slots 0..7, in arrival order.
- and_w  output  WIDTH  a&b&c&d&e&f&g&h.
- q  output  WIDTH  {WIDTH-1 zeros, &{a..h}}: bit 0 is 1 iff every bit of every slot is 1.
- cnt  output  4  number of real words in the frame, 1..8.

## Operation
- Two states.
  - COLLECT: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1.
- Reset values: state COLLECT, slot index 0, a..h all-ones, and_w all-ones, q 0, cnt 0, out_valid 0.
- Transfer rules:
  - Input transfer is in_valid && in_ready.
  - Output transfer is out_valid && out_ready.
- Input transfer in COLLECT:
  - Writes in_data into slot[idx].
  - Updates and_w with and_w & in_data.
  - Increments idx.
- Frame close: a transfer with idx==7 or with in_last=1 closes the frame.
  - State goes to HOLD.
  - cnt is set to idx+1.
  - q bit 0 is set to &(and_w & in_data), registered.
  - idx returns to 0.
- Unwritten slots keep all-ones. in_last on the 8th word behaves the same as a full frame.
- In HOLD:
  - a..h, and_w, q and cnt are held stable.
  - in_valid is ignored; no word is lost because in_ready=0.
- Output transfer in HOLD:
  - State goes to COLLECT.
  - a..h and and_w are reset to all-ones.
  - q and cnt are reset to 0.
- Outputs during COLLECT show the partial frame. They are undefined for consumers, since out_valid=0.
- Reset asserted mid-frame discards the partial frame and returns all registers to their reset values on the next edge.

## Timing
- in_ready and out_valid are pure register decodes of the state, with no combinational path from in_valid or out_ready.
- Latency: out_valid rises on the cycle after the closing input transfer.
- Throughput:
  - A full frame takes 8 input cycles plus at least 1 HOLD cycle.
  - in_ready returns high on the cycle after the output transfer.
  - Best case is 9 cycles per 8-word frame.
- in_data and in_last are sampled only on input transfer cycles. in_last without in_valid is ignored.
- Output backpressure of any length holds all outputs bit-stable.
- A reset cycle overrides any simultaneous input or output transfer.

## Structure
- Shared package holds:
  - the state enum (COLLECT, HOLD);
  - SLOT_NUM=8;
  - IDX_W=3;
  - CNT_W=4.
- Slot storage is an internal SLOT_NUM x WIDTH array mapped onto ports a..h.
- One sub-module is natural: port_deserializer_ctrl, containing the FSM, idx counter and cnt. The datapath stays in the top module.

## Test plan
- WIDTH=7, eight words 0x7F with no in_last → out_valid on cycle 9, a..h=0x7F, and_w=0x7F, q=0x01, cnt=8.
- WIDTH=7, words 0x7F,0x7F,0x7F,0x3F,0x7F,0x7F,0x7F,0x7F → d=0x3F, and_w=0x3F, q=0x00, cnt=8.
- WIDTH=7, three words 0x55,0x7F,0x7F with in_last on the third → a=0x55, b=c=0x7F, d..h=0x7F, and_w=0x55, q=0, cnt=3.
- Full frame, then out_ready low for 5 cycles while in_valid=1 with data 0x00 → in_ready=0 throughout, outputs unchanged. After out_ready=1, in_ready=1 next cycle and the next frame begins with 0x00 in slot a.
- Reset (rst_n=0 for 1 cycle) after 4 accepted words → next cycle shows out_valid=0, in_ready=1, a..h=0x7F, cnt=0. The following 8 words form a fresh frame starting at slot a.
- Random in_valid/out_ready gaps over 10 frames with $random data → every frame's a..h, and_w and q match a scoreboard model, with no dropped or duplicated words.
